// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the asynchronous FIFO.
// Owns the binary/Gray read pointer, derives empty, almost-empty and fill
// level from the synchronized write pointer, and drives a registered RAM
// into a 2-entry output buffer that presents a valid/ready stream.
module fifo_rd_ctrl #(
  parameter int ADDRSIZE      = 4,
  parameter int DSIZE         = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                ren,
  input  logic [DSIZE-1:0]    rdata_mem,
  output logic [DSIZE-1:0]    rdata,
  output logic                rvalid,
  input  logic                rready,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int                PW        = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_THRESH = PW'(AEMPTY_THRESH);
  localparam logic [ADDRSIZE:0] FULL_LVL  = PW'(1 << ADDRSIZE);

  // Output buffer occupancy: empty, head only, head plus skid.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } occ_e;

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pointer and flag state
  logic [ADDRSIZE:0] rbin_q;
  logic [ADDRSIZE:0] rptr_q;
  logic              rempty_q;
  logic              raempty_q;
  logic [ADDRSIZE:0] rlevel_q;

  // RAM read in flight: data lands on rdata_mem one cycle after ren
  logic              vld_p1_q;

  // Output buffer state
  occ_e              occ_q;
  logic              rvalid_q;
  logic [DSIZE-1:0]  head_q;
  logic [DSIZE-1:0]  skid_q;

  logic [ADDRSIZE:0] rbin_d;
  logic [ADDRSIZE:0] rgray_d;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] lvl_d;
  logic              arr;
  logic              pop;
  logic              buf_room;
  logic              skid_load;

  assign arr = vld_p1_q;
  assign pop = rvalid_q && rready;

  // Room exists when buffered plus in-flight words stay below two; a pop this
  // cycle frees a slot, which lets a full buffer keep streaming at one word per
  // cycle. The rready dependence is intentionally combinational.
  assign buf_room = (occ_q == B0) || ((occ_q == B1) && !vld_p1_q);
  assign ren      = !rempty_q && (buf_room || pop);

  assign rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, ren};
  assign rgray_d = bin2gray(rbin_d);
  assign wbin    = gray2bin(rq2_wptr);
  // Modular subtraction; a full RAM (2**ADDRSIZE) is still representable.
  assign lvl_d   = wbin - rbin_d;

  // Skid loads when an arrival cannot go to the head slot.
  assign skid_load = arr && (((occ_q == B1) && !pop) || ((occ_q == B2) && pop));

  assign raddr         = rbin_q[ADDRSIZE-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = raempty_q;
  assign rlevel        = rlevel_q;
  assign rvalid        = rvalid_q;
  assign rdata         = head_q;

  // Read pointer advance and flag/level update, evaluated against the
  // post-increment pointer so a read and a write-pointer change in the same
  // cycle are both reflected.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rlevel_q  <= '0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rgray_d;
      rempty_q  <= (rgray_d == rq2_wptr);
      raempty_q <= (lvl_d <= AE_THRESH);
      rlevel_q  <= lvl_d;
    end
  end

  // RAM latency tracker: marks the cycle in which rdata_mem carries a word.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= ren;
    end
  end

  // Output buffer FSM: head register drives the stream, skid holds the second
  // word when the consumer stalls.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q    <= B0;
      rvalid_q <= 1'b0;
      head_q   <= '0;
    end else begin
      case (occ_q)
        B0: begin
          if (arr) begin
            head_q   <= rdata_mem;
            occ_q    <= B1;
            rvalid_q <= 1'b1;
          end
        end
        B1: begin
          if (arr && !pop) begin
            occ_q <= B2;
          end else if (!arr && pop) begin
            occ_q    <= B0;
            rvalid_q <= 1'b0;
          end else if (arr && pop) begin
            head_q <= rdata_mem;
          end
        end
        B2: begin
          if (pop) begin
            head_q <= skid_q;
            if (!arr) begin
              occ_q <= B1;
            end
          end
        end
        default: begin
          occ_q    <= B0;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Skid data register; contents only matter while occupancy is B2.
  always_ff @(posedge rclk) begin
    if (skid_load) begin
      skid_q <= rdata_mem;
    end
  end

`ifndef SYNTHESIS
  // Buffered plus in-flight words never exceed the two buffer slots.
  a_occ_bound: assert property (@(posedge rclk) disable iff (!rrst_n)
    !((occ_q == B2) && vld_p1_q));

  // Stream data holds while stalled.
  a_hold: assert property (@(posedge rclk) disable iff (!rrst_n)
    (rvalid_q && !rready) |=> $stable(head_q));

  // Level never exceeds the RAM depth.
  a_lvl_bound: assert property (@(posedge rclk) disable iff (!rrst_n)
    rlevel_q <= FULL_LVL);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl against a word-count reference model.
module tb_fifo_rd_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int TH    = 2;
  localparam int DEPTH = 1 << AW;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [AW:0]   rq2_wptr;
  logic [AW:0]   rptr;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [DW-1:0] rdata_mem;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  logic          rempty;
  logic          ralmost_empty;
  logic [AW:0]   rlevel;

  fifo_rd_ctrl #(
    .ADDRSIZE      (AW),
    .DSIZE         (DW),
    .AEMPTY_THRESH (TH)
  ) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rq2_wptr      (rq2_wptr),
    .rptr          (rptr),
    .raddr         (raddr),
    .ren           (ren),
    .rdata_mem     (rdata_mem),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .rready        (rready),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel)
  );

  always #5 rclk = ~rclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Write-side model: RAM contents, every word ever written in order, and
  // the write count as seen through the two-flop synchronizer.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] items [$];
  int            wcnt, w_d1, w_d2;

  // Read-side model in word counts: reads issued, words consumed.
  int            m_rd, m_pop, m_level;
  bit            m_empty, m_ren_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    int m;
    m = b & ((2 * DEPTH) - 1);
    return (m >> 1) ^ m;
  endfunction

  task automatic model_clear();
    items.delete();
    wcnt       = 0;
    w_d1       = 0;
    w_d2       = 0;
    m_rd       = 0;
    m_pop      = 0;
    m_level    = 0;
    m_empty    = 1'b1;
    m_ren_prev = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_rvalid", rvalid, 0);
    chk("rst_ren", ren, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_raempty", ralmost_empty, 1);
    chk("rst_rlevel", rlevel, 0);
    chk("rst_rptr", rptr, 0);
    chk("rst_rdata", rdata, 0);
  endtask

  // One clock: randomize rready, check all outputs mid-cycle against the
  // model, then advance the model and the write side past the edge.
  task automatic step(input int rr_pct, input int wr_pct);
    bit            valid, pop, xren;
    logic [DW-1:0] d;
    rready = ($urandom_range(99) < rr_pct);
    @(negedge rclk);
    valid = (m_rd - int'(m_ren_prev) - m_pop) > 0;
    pop   = valid && rready;
    xren  = !m_empty && (((m_rd - m_pop) < 2) || pop);
    chk("ren", ren, xren);
    chk("raddr", raddr, m_rd % DEPTH);
    chk("rvalid", rvalid, valid);
    if (valid) chk("rdata", rdata, items[m_pop]);
    chk("rempty", rempty, m_empty);
    chk("ralmost_empty", ralmost_empty, (m_level <= TH));
    chk("rlevel", rlevel, m_level);
    chk("rptr", rptr, gray(m_rd));
    @(posedge rclk);
    #1;
    rdata_mem  = xren ? mem[m_rd % DEPTH] : DW'($urandom);
    m_pop     += int'(pop);
    m_rd      += int'(xren);
    m_ren_prev = xren;
    m_empty    = (w_d2 == m_rd);
    m_level    = w_d2 - m_rd;
    w_d2       = w_d1;
    w_d1       = wcnt;
    if ((wcnt - m_rd) < DEPTH && $urandom_range(99) < wr_pct) begin
      d = DW'($urandom);
      mem[wcnt % DEPTH] = d;
      items.push_back(d);
      wcnt++;
    end
    rq2_wptr = (AW+1)'(gray(w_d2));
  endtask

  initial begin
    rrst_n    = 1'b0;
    rready    = 1'b0;
    rdata_mem = '0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      mem[i] = DW'(8'h10 + i);
      items.push_back(DW'(8'h10 + i));
    end
    wcnt     = 4;
    w_d1     = 4;
    w_d2     = 4;
    rq2_wptr = (AW+1)'(gray(4));

    repeat (3) @(posedge rclk);
    #1;
    check_reset_vals();
    rrst_n = 1'b1;

    // Preloaded 0x10..0x13 streamed with the consumer always ready
    repeat (10) step(100, 0);
    // Consumer stalled while the writer fills the RAM to its depth
    repeat (30) step(0, 100);
    chk("full_rlevel", rlevel, DEPTH);
    chk("full_rempty", rempty, 0);
    // Drain through the almost-empty threshold to empty
    repeat (30) step(100, 0);
    // Mixed random traffic, wrapping the pointers many times
    repeat (1500) step(50, 50);

    // Reset with words buffered and a read in flight
    repeat (8) step(0, 100);
    step(0, 100);
    rrst_n = 1'b0;
    #1;
    check_reset_vals();
    model_clear();
    rq2_wptr = '0;
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;

    repeat (1500) step(70, 60);
    repeat (300) step(100, 100);
    repeat (300) step(20, 90);
    repeat (50) step(100, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
